// File: rtl/ovl_delta_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ovl_delta_cfg_ctrl
// Brief   : Config controller and fire collector for a bank of delta-checker slots
// Revision: 1.0
// ============================================================================
module ovl_delta_cfg_ctrl #(
    parameter int NUM_SLOTS = 4,
    parameter int LIMIT_W   = 3,
    parameter int SLOT_W    = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [SLOT_W-1:0]            cfg_slot,
    input  logic [LIMIT_W-1:0]           cfg_min,
    input  logic [LIMIT_W-1:0]           cfg_max,
    input  logic                         cfg_enable,
    output logic                         cfg_err,
    output logic [NUM_SLOTS*LIMIT_W-1:0] slot_min,
    output logic [NUM_SLOTS*LIMIT_W-1:0] slot_max,
    output logic [NUM_SLOTS-1:0]         slot_prev_invalid,
    input  logic [NUM_SLOTS-1:0]         slot_out,
    output logic [NUM_SLOTS-1:0]         fire_sticky,
    output logic                         fire_valid,
    output logic [SLOT_W-1:0]            fire_slot,
    input  logic                         fire_ack
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CHECK  = 3'd1;
    localparam logic [2:0] REJECT = 3'd2;
    localparam logic [2:0] APPLY  = 3'd3;
    localparam logic [2:0] SETTLE = 3'd4;

    logic [2:0]           state, state_nx;
    logic [SLOT_W-1:0]    req_slot;
    logic [LIMIT_W-1:0]   req_min, req_max;
    logic                 req_en;
    logic [1:0]           settle_cnt;
    logic [NUM_SLOTS-1:0] slot_enable, enable_nx, prev_inv_nx, apply_mask, events;
    logic [SLOT_W-1:0]    first_slot;
    logic                 bad_req;

    // A disarm request is legal regardless of its limits.
    assign bad_req = (32'(req_slot) >= NUM_SLOTS) || (req_en && (req_min > req_max));

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cfg_valid && cfg_ready) state_nx = CHECK;
            CHECK:   state_nx = bad_req ? REJECT : APPLY;
            REJECT:  state_nx = IDLE;
            APPLY:   state_nx = SETTLE;
            SETTLE:  if (settle_cnt == 2'd1) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // prev_invalid is registered, so it is derived from the next state and next enables.
    always_comb begin
        apply_mask  = '0;
        enable_nx   = slot_enable;
        prev_inv_nx = '0;
        events      = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            apply_mask[i]  = (state == APPLY) && (req_slot == SLOT_W'(i));
            enable_nx[i]   = apply_mask[i] ? req_en : slot_enable[i];
            prev_inv_nx[i] = (((state_nx == APPLY) || (state_nx == SETTLE)) &&
                              (req_slot == SLOT_W'(i))) || !enable_nx[i];
            events[i]      = slot_out[i] && slot_enable[i] && !slot_prev_invalid[i];
        end
    end

    always_comb begin
        first_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (events[i]) first_slot = SLOT_W'(i);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state             <= IDLE;
            cfg_ready         <= 1'b1;
            cfg_err           <= 1'b0;
            req_slot          <= '0;
            req_min           <= '0;
            req_max           <= '0;
            req_en            <= 1'b0;
            settle_cnt        <= '0;
            slot_min          <= '0;
            slot_max          <= '0;
            slot_enable       <= '0;
            slot_prev_invalid <= '1;
            fire_sticky       <= '0;
            fire_valid        <= 1'b0;
            fire_slot         <= '0;
        end else begin
            state             <= state_nx;
            cfg_ready         <= (state_nx == IDLE);
            cfg_err           <= (state == CHECK) && bad_req;
            slot_enable       <= enable_nx;
            slot_prev_invalid <= prev_inv_nx;

            if ((state == IDLE) && cfg_valid && cfg_ready) begin
                req_slot <= cfg_slot;
                req_min  <= cfg_min;
                req_max  <= cfg_max;
                req_en   <= cfg_enable;
            end

            if (state == APPLY)       settle_cnt <= 2'd2;
            else if (state == SETTLE) settle_cnt <= settle_cnt - 2'd1;

            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (apply_mask[i]) begin
                    slot_min[i*LIMIT_W +: LIMIT_W] <= req_min;
                    slot_max[i*LIMIT_W +: LIMIT_W] <= req_max;
                end
            end

            // A reconfigure clears the slot's sticky bit even if it fires this cycle.
            fire_sticky <= (fire_sticky | events) & ~apply_mask;

            if ((|events) && (!fire_valid || fire_ack)) begin
                fire_valid <= 1'b1;
                fire_slot  <= first_slot;
            end else if (fire_ack) begin
                fire_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ovl_delta_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ovl_delta_cfg_ctrl
// Brief   : Directed plus randomized bench with a timeline-based reference model
// Revision: 1.0
// ============================================================================
module tb_ovl_delta_cfg_ctrl;

    localparam int NS = 4;
    localparam int LW = 3;
    localparam int SW = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic              cfg_valid, cfg_enable, fire_ack;
    logic [SW-1:0]     cfg_slot;
    logic [LW-1:0]     cfg_min, cfg_max;
    logic [NS-1:0]     slot_out;
    logic              cfg_ready, cfg_err, fire_valid;
    logic [NS*LW-1:0]  slot_min, slot_max;
    logic [NS-1:0]     slot_prev_invalid, fire_sticky;
    logic [SW-1:0]     fire_slot;

    logic              d3_valid, d3_en, d3_ack;
    logic [SW-1:0]     d3_slot;
    logic [LW-1:0]     d3_min, d3_max;
    logic [2:0]        d3_out;
    logic              d3_ready, d3_err, d3_fv;
    logic [3*LW-1:0]   d3_smin, d3_smax;
    logic [2:0]        d3_pinv, d3_sticky;
    logic [SW-1:0]     d3_fs;

    ovl_delta_cfg_ctrl #(.NUM_SLOTS(NS), .LIMIT_W(LW), .SLOT_W(SW)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_slot(cfg_slot), .cfg_min(cfg_min), .cfg_max(cfg_max),
        .cfg_enable(cfg_enable), .cfg_err(cfg_err), .slot_min(slot_min),
        .slot_max(slot_max), .slot_prev_invalid(slot_prev_invalid),
        .slot_out(slot_out), .fire_sticky(fire_sticky), .fire_valid(fire_valid),
        .fire_slot(fire_slot), .fire_ack(fire_ack)
    );

    ovl_delta_cfg_ctrl #(.NUM_SLOTS(3), .LIMIT_W(LW), .SLOT_W(SW)) dut3 (
        .clk(clk), .rst(rst), .cfg_valid(d3_valid), .cfg_ready(d3_ready),
        .cfg_slot(d3_slot), .cfg_min(d3_min), .cfg_max(d3_max),
        .cfg_enable(d3_en), .cfg_err(d3_err), .slot_min(d3_smin),
        .slot_max(d3_smax), .slot_prev_invalid(d3_pinv),
        .slot_out(d3_out), .fire_sticky(d3_sticky), .fire_valid(d3_fv),
        .fire_slot(d3_fs), .fire_ack(d3_ack)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: committed slot config plus the timeline of the pending request.
    int          m_min[NS], m_max[NS];
    bit          m_en[NS];
    int          ready_at, err_at, apply_at, win_lo, win_hi, win_slot;
    int          ap_slot, ap_min, ap_max;
    bit          ap_en;
    bit [NS-1:0] m_sticky;
    bit          m_fv;
    int          m_fs;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NS; i++) begin
            m_min[i] = 0; m_max[i] = 0; m_en[i] = 1'b0;
        end
        ready_at = cyc; err_at = -1; apply_at = -1;
        win_lo = -1; win_hi = -2; win_slot = -1;
        ap_slot = 0; ap_min = 0; ap_max = 0; ap_en = 1'b0;
        m_sticky = '0; m_fv = 1'b0; m_fs = 0;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_ready"}, 32'(cfg_ready), 32'd1);
        chk({tag, "_err"},   32'(cfg_err), 32'd0);
        chk({tag, "_min"},   32'(slot_min), 32'd0);
        chk({tag, "_max"},   32'(slot_max), 32'd0);
        chk({tag, "_pinv"},  32'(slot_prev_invalid), 32'hF);
        chk({tag, "_stk"},   32'(fire_sticky), 32'd0);
        chk({tag, "_fv"},    32'(fire_valid), 32'd0);
        chk({tag, "_fs"},    32'(fire_slot), 32'd0);
    endtask

    // One cycle: drive inputs, compare outputs with the model, advance the model and clock.
    task automatic step(input bit v, input int slot, input int mn, input int mx,
                        input bit en, input logic [NS-1:0] o, input bit ack);
        logic [NS*LW-1:0] emin, emax;
        logic [NS-1:0]    epinv, ev;
        int               first;
        bit               bad;
        cfg_valid = v; cfg_slot = SW'(slot); cfg_min = LW'(mn); cfg_max = LW'(mx);
        cfg_enable = en; slot_out = o; fire_ack = ack;
        for (int i = 0; i < NS; i++) begin
            emin[i*LW +: LW] = LW'(m_min[i]);
            emax[i*LW +: LW] = LW'(m_max[i]);
            epinv[i] = (cyc >= win_lo && cyc <= win_hi && i == win_slot) ? 1'b1 : !m_en[i];
        end
        chk("cfg_ready", 32'(cfg_ready), 32'(cyc >= ready_at));
        chk("cfg_err", 32'(cfg_err), 32'(cyc == err_at));
        chk("slot_min", 32'(slot_min), 32'(emin));
        chk("slot_max", 32'(slot_max), 32'(emax));
        chk("prev_invalid", 32'(slot_prev_invalid), 32'(epinv));
        chk("fire_sticky", 32'(fire_sticky), 32'(m_sticky));
        chk("fire_valid", 32'(fire_valid), 32'(m_fv));
        chk("fire_slot", 32'(fire_slot), 32'(m_fs));

        first = -1;
        for (int i = 0; i < NS; i++) begin
            ev[i] = o[i] && m_en[i] && !epinv[i];
            if (ev[i] && first < 0) first = i;
        end
        m_sticky = m_sticky | ev;
        if (first >= 0 && (!m_fv || ack)) begin
            m_fv = 1'b1; m_fs = first;
        end else if (ack) begin
            m_fv = 1'b0;
        end
        if (cyc == apply_at) begin
            m_sticky[ap_slot] = 1'b0;
            m_min[ap_slot] = ap_min; m_max[ap_slot] = ap_max; m_en[ap_slot] = ap_en;
        end
        if (v && cyc >= ready_at) begin
            bad = (slot >= NS) || (en && mn > mx);
            if (bad) begin
                err_at = cyc + 2; ready_at = cyc + 3;
            end else begin
                apply_at = cyc + 2; win_lo = cyc + 2; win_hi = cyc + 4; win_slot = slot;
                ready_at = cyc + 5;
                ap_slot = slot; ap_min = mn; ap_max = mx; ap_en = en;
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 0, 0, 0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        cfg_valid = 1'b0; cfg_slot = '0; cfg_min = '0; cfg_max = '0; cfg_enable = 1'b0;
        slot_out = '0; fire_ack = 1'b0;
        d3_valid = 1'b0; d3_slot = '0; d3_min = '0; d3_max = '0; d3_en = 1'b0;
        d3_out = '0; d3_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b1;
        model_reset();
        idle(2);

        // Accepted write: slot 1, min 2, max 5, enabled.
        step(1'b1, 1, 2, 5, 1'b1, '0, 1'b0);
        idle(2);
        chk("slot1_max_T3", 32'(slot_max[5:3]), 32'd5);
        idle(2);
        chk("pinv_T5", 32'(slot_prev_invalid), 32'hD);
        chk("ready_T5", 32'(cfg_ready), 32'd1);

        // Rejected write: min > max on an enable.
        step(1'b1, 0, 6, 2, 1'b1, '0, 1'b0);
        idle(1);
        chk("reject_err_T2", 32'(cfg_err), 32'd1);
        idle(1);
        chk("reject_ready_T3", 32'(cfg_ready), 32'd1);
        chk("reject_min0", 32'(slot_min[2:0]), 32'd0);

        // Arm slot 3, then two simultaneous events and acknowledgement flow.
        step(1'b1, 3, 0, 7, 1'b1, '0, 1'b0);
        idle(5);
        step(1'b0, 0, 0, 0, 1'b0, 4'b1010, 1'b0);
        chk("fire_sticky_1010", 32'(fire_sticky), 32'hA);
        chk("fire_slot_first", 32'(fire_slot), 32'd1);
        step(1'b0, 0, 0, 0, 1'b0, 4'b1000, 1'b1);
        chk("fire_slot_after_ack", 32'(fire_slot), 32'd3);
        chk("fire_valid_after_ack", 32'(fire_valid), 32'd1);
        step(1'b0, 0, 0, 0, 1'b0, '0, 1'b1);
        chk("fire_valid_cleared", 32'(fire_valid), 32'd0);

        // slot_out[1] held high across a reconfigure of slot 1.
        step(1'b1, 1, 1, 3, 1'b1, 4'b0010, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0, 4'b0010, 1'b0);
        step(1'b0, 0, 0, 0, 1'b0, 4'b0010, 1'b0);
        chk("sticky1_cleared_T3", 32'(fire_sticky[1]), 32'd0);
        for (int k = 0; k < 4; k++) step(1'b0, 0, 0, 0, 1'b0, 4'b0010, 1'b0);
        idle(1);

        // Reset asserted during SETTLE.
        step(1'b1, 0, 1, 1, 1'b1, '0, 1'b0);
        idle(2);
        cfg_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk_reset("midreset");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        model_reset();
        chk_reset("postreset");
        idle(1);

        // Three-slot instance: out-of-range slot rejected, disarm with min > max accepted.
        d3_valid = 1'b1; d3_slot = 2'd3; d3_min = 3'd1; d3_max = 3'd2; d3_en = 1'b1;
        idle(1);
        d3_valid = 1'b0;
        idle(1);
        chk("d3_oob_err", 32'(d3_err), 32'd1);
        idle(1);
        chk("d3_oob_ready", 32'(d3_ready), 32'd1);
        chk("d3_oob_min", 32'(d3_smin), 32'd0);
        chk("d3_oob_max", 32'(d3_smax), 32'd0);
        d3_valid = 1'b1; d3_slot = 2'd2; d3_min = 3'd7; d3_max = 3'd0; d3_en = 1'b0;
        idle(1);
        d3_valid = 1'b0;
        idle(1);
        chk("d3_dis_err", 32'(d3_err), 32'd0);
        idle(1);
        chk("d3_dis_min", 32'(d3_smin[8:6]), 32'd7);
        chk("d3_dis_max", 32'(d3_smax[8:6]), 32'd0);
        idle(2);
        chk("d3_dis_ready", 32'(d3_ready), 32'd1);
        chk("d3_dis_pinv", 32'(d3_pinv), 32'h7);
        chk("d3_quiet", 32'({d3_sticky, d3_fv, d3_fs}), 32'd0);

        // Randomized traffic against the model.
        for (int k = 0; k < 800; k++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) != 0), NS'($urandom) & NS'($urandom | $urandom),
                 ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ovl_delta_cfg_ctrl.md
# ovl_delta_cfg_ctrl

Configuration controller and event collector for a bank of NUM_SLOTS delta-checker slots, each of which flags an out-of-range step in a monitored value. It accepts per-slot min/max/enable writes over a valid/ready handshake and rejects illegal configurations. After every accepted write it drives the slot's prevConfigInvalid long enough to mask stale deltas. It also gathers the slots' out pulses into sticky status and a first-fire record for the fabric's monitor.

## Interface
- NUM_SLOTS, 4: number of checker slots (2..16).
- LIMIT_W, 3: width of the min/max limits.
- SLOT_W, 2: width of the slot index; must satisfy 2**SLOT_W >= NUM_SLOTS.

- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config request present.
- cfg_ready  out  1  controller can accept a request.
- cfg_slot  in  SLOT_W  target slot.
- cfg_min  in  LIMIT_W  new min delta.
- cfg_max  in  LIMIT_W  new max delta.
- cfg_enable  in  1  1 = arm slot, 0 = disarm.
- cfg_err  out  1  one-cycle pulse: request rejected.
- slot_min  out  NUM_SLOTS*LIMIT_W  per-slot min; slot i in bits [i*LIMIT_W +: LIMIT_W].
- slot_max  out  NUM_SLOTS*LIMIT_W  per-slot max; same packing as slot_min.
- slot_prev_invalid  out  NUM_SLOTS  drives each checker's prevConfigInvalid.
- slot_out  in  NUM_SLOTS  checker out bits.
- fire_sticky  out  NUM_SLOTS  sticky fire status.
- fire_valid  out  1  first-fire record holds an event.
- fire_slot  out  SLOT_W  slot of the recorded event.
- fire_ack  in  1  consume the first-fire record.

## Operation
- Reset (rst low, async):
  - state IDLE; cfg_ready 1.
  - slot_min, slot_max, slot_enable (internal), fire_sticky, fire_valid, fire_slot and cfg_err all 0.
  - slot_prev_invalid all 1.
  - An in-flight request is discarded.
- FSM states: IDLE, CHECK, REJECT, APPLY, SETTLE.
- IDLE:
  - cfg_ready = 1; it is 0 in every other state.
  - When cfg_valid && cfg_ready, latch slot/min/max/enable and go to CHECK.
- CHECK (1 cycle):
  - If cfg_slot >= NUM_SLOTS, or cfg_enable && cfg_min > cfg_max (unsigned compare), go to REJECT.
  - Otherwise go to APPLY.
  - A disable request skips the min>max check.
- REJECT (1 cycle): cfg_err = 1; no slot state changes; go to IDLE.
- APPLY (1 cycle):
  - Write slot_min, slot_max and slot_enable for the target slot; clear its fire_sticky bit.
  - slot_prev_invalid[slot] = 1.
  - Load the settle counter with 2; go to SETTLE.
- SETTLE:
  - slot_prev_invalid[slot] stays 1; the counter decrements each cycle.
  - Leave to IDLE when the counter reaches 0. SETTLE lasts exactly 2 cycles.
- slot_prev_invalid[i] for a slot not being configured is ~slot_enable[i]. A disarmed slot is held invalid permanently.
- Fire collection:
  - A slot event is slot_out[i] && slot_enable[i] && ~slot_prev_invalid[i].
  - An event sets fire_sticky[i]. The bit clears only on reset or on an APPLY to slot i; APPLY wins over a same-cycle event.
  - If fire_valid is 0, or fire_ack is 1 in that cycle, and any event occurs: fire_valid <= 1 and fire_slot <= lowest-indexed event slot.
  - fire_ack with no event clears fire_valid; fire_slot holds its value.
  - fire_ack while fire_valid is 0 is ignored.

## Timing
- Request handshake cycle T goes to CHECK at T+1.
- Accepted request: APPLY at T+2, with new limits visible on slot_min/slot_max from T+3.
  - slot_prev_invalid[slot] is high over T+2..T+4 (APPLY plus SETTLE).
  - It drops at T+5 if enabled; it stays high if disabled.
  - cfg_ready returns at T+5.
- Rejected request: cfg_err high at T+2; cfg_ready returns at T+3.
- Sustained throughput: 1 request per 5 cycles accepted, 1 per 3 rejected.
- An event at cycle E appears on fire_sticky and fire_valid/fire_slot at E+1.
- All outputs are registered.

## Test plan
- Reset release, then write slot 1, min 2, max 5, enable 1 at T:
  - slot_max[5:3] = 5 at T+3.
  - slot_prev_invalid = 4'b1111 over T+2..T+4, then 4'b1101 at T+5.
  - cfg_ready = 0 over T+1..T+4, then 1 at T+5.
- Write slot 0, min 6, max 2, enable 1: cfg_err pulses 1 cycle at T+2; slot_min and slot_max stay 0; cfg_ready = 1 at T+3.
- NUM_SLOTS = 3 with a write to cfg_slot = 3: rejected with cfg_err and no state change. Write slot 2, min 7, max 0, enable 0: accepted with no error.
- Slots 1 and 3 enabled, slot_out = 4'b1010 for one cycle:
  - Next cycle fire_sticky = 4'b1010, fire_valid = 1, fire_slot = 1.
  - Then fire_ack together with slot_out = 4'b1000 gives fire_slot = 3, fire_valid = 1.
  - Then fire_ack alone gives fire_valid = 0.
- slot_out[1] held high through a reconfigure of slot 1: no new sticky bit or fire record while slot_prev_invalid[1] = 1. Sticky bit 1 clears at APPLY.
- Drop rst low during SETTLE: outputs go to reset values immediately. After release, cfg_ready = 1 and slot_prev_invalid = all 1.
